// File: rtl/turf_buffer_manager.sv
// Ring-based SURF buffer manager for the TURF trigger path.
// Allocates HOLD buffers to accepted triggers and releases them oldest-first.
module turf_buffer_manager #(
  parameter int NUM_BUFFERS = 4,
  parameter int BUF_BITS    = 2,
  parameter int EVID_BITS   = 20,
  parameter int EPOCH_BITS  = 12,
  parameter int HOLDOFF     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trig_i,
  input  logic                  disable_i,
  input  logic                  clr_evt_i,
  input  logic                  clr_all_i,
  input  logic [EPOCH_BITS-1:0] epoch_i,
  input  logic                  evid_reset_i,
  output logic [NUM_BUFFERS-1:0] hold_o,
  output logic                  trig_accept_o,
  output logic [BUF_BITS-1:0]   trig_buf_o,
  output logic [31:0]           next_id_o,
  output logic [BUF_BITS:0]     occupancy_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [15:0]           dropped_o,
  output logic [31:0]           status_o
);

  localparam int HO_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;

  typedef enum logic {
    ST_ARMED,
    ST_HOLDOFF
  } state_t;

  state_t                 state_q;
  logic [HO_W-1:0]        ho_cnt_q;
  logic [BUF_BITS-1:0]    wp_q;
  logic [BUF_BITS-1:0]    rp_q;
  logic [EVID_BITS-1:0]   evid_q;
  logic [EPOCH_BITS-1:0]  epoch_q;
  logic [NUM_BUFFERS-1:0] hold_next;
  logic [7:0]             hold_lo;
  logic                   accept;
  logic                   drop;
  logic                   clr_ok;

  assign full_o  = (occupancy_o == (BUF_BITS+1)'(NUM_BUFFERS));
  assign empty_o = (occupancy_o == '0);

  // full_o is the registered occupancy, so a clear in the same cycle cannot free room for a trigger
  assign accept = trig_i & ~disable_i & ~full_o & (state_q == ST_ARMED);
  assign drop   = trig_i & ~disable_i & (full_o | (state_q == ST_HOLDOFF));
  assign clr_ok = clr_evt_i & ~empty_o;

  always_comb begin
    hold_next = hold_o;
    if (accept) hold_next[wp_q] = 1'b1;
    if (clr_ok) hold_next[rp_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_ARMED;
      ho_cnt_q      <= '0;
      wp_q          <= '0;
      rp_q          <= '0;
      evid_q        <= '0;
      epoch_q       <= '0;
      hold_o        <= '0;
      trig_accept_o <= 1'b0;
      trig_buf_o    <= '0;
      occupancy_o   <= '0;
      dropped_o     <= '0;
    end else begin
      trig_accept_o <= 1'b0;

      // a trigger accepted alongside evid_reset is numbered after the reset
      if (evid_reset_i) begin
        epoch_q <= epoch_i;
        evid_q  <= (accept & ~clr_all_i) ? EVID_BITS'(1) : '0;
      end else if (accept & ~clr_all_i) begin
        evid_q <= evid_q + EVID_BITS'(1);
      end

      if (clr_all_i) begin
        state_q     <= ST_ARMED;
        ho_cnt_q    <= '0;
        wp_q        <= '0;
        rp_q        <= '0;
        hold_o      <= '0;
        occupancy_o <= '0;
        dropped_o   <= '0;
      end else begin
        hold_o <= hold_next;
        if (accept) begin
          trig_buf_o    <= wp_q;
          trig_accept_o <= 1'b1;
          wp_q          <= wp_q + 1'b1;
        end
        if (clr_ok) rp_q <= rp_q + 1'b1;

        case ({accept, clr_ok})
          2'b10:   occupancy_o <= occupancy_o + 1'b1;
          2'b01:   occupancy_o <= occupancy_o - 1'b1;
          default: occupancy_o <= occupancy_o;
        endcase

        if (drop && (dropped_o != 16'hFFFF)) dropped_o <= dropped_o + 16'd1;

        case (state_q)
          ST_ARMED: begin
            if (accept && (HOLDOFF > 0)) begin
              state_q  <= ST_HOLDOFF;
              ho_cnt_q <= HO_W'(HOLDOFF - 1);
            end
          end
          ST_HOLDOFF: begin
            if (ho_cnt_q == '0) state_q <= ST_ARMED;
            else                ho_cnt_q <= ho_cnt_q - 1'b1;
          end
          default: state_q <= ST_ARMED;
        endcase
      end
    end
  end

  generate
    if (NUM_BUFFERS >= 8) begin : g_hold_wide
      assign hold_lo = hold_o[7:0];
    end else begin : g_hold_narrow
      assign hold_lo = 8'(hold_o);
    end
  endgenerate

  assign next_id_o = {epoch_q, evid_q};
  assign status_o  = {dropped_o, 8'h00, 8'(occupancy_o), hold_lo};

endmodule

// File: tb/tb_turf_buffer_manager.sv
// Bench for turf_buffer_manager: 4- and 8-buffer instances driven in parallel,
// directed table, hand sequences and random traffic against a sequence-number model.
module tb_turf_buffer_manager;

  logic        clk = 1'b0;
  logic        rst, trig, dis, clr_evt, clr_all, evid_reset;
  logic [11:0] epoch;

  logic [3:0]  hold4;  logic acc4; logic [1:0] buf4; logic [31:0] id4;
  logic [2:0]  occ4;   logic full4, empty4; logic [15:0] drop4; logic [31:0] stat4;
  logic [7:0]  hold8;  logic acc8; logic [2:0] buf8; logic [31:0] id8;
  logic [3:0]  occ8;   logic full8, empty8; logic [15:0] drop8; logic [31:0] stat8;

  always #5 clk = ~clk;

  turf_buffer_manager #(.NUM_BUFFERS(4), .BUF_BITS(2), .HOLDOFF(8)) dut4 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .disable_i(dis), .clr_evt_i(clr_evt),
    .clr_all_i(clr_all), .epoch_i(epoch), .evid_reset_i(evid_reset),
    .hold_o(hold4), .trig_accept_o(acc4), .trig_buf_o(buf4), .next_id_o(id4),
    .occupancy_o(occ4), .full_o(full4), .empty_o(empty4), .dropped_o(drop4), .status_o(stat4));

  turf_buffer_manager #(.NUM_BUFFERS(8), .BUF_BITS(3), .HOLDOFF(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .disable_i(dis), .clr_evt_i(clr_evt),
    .clr_all_i(clr_all), .epoch_i(epoch), .evid_reset_i(evid_reset),
    .hold_o(hold8), .trig_accept_o(acc8), .trig_buf_o(buf8), .next_id_o(id8),
    .occupancy_o(occ8), .full_o(full8), .empty_o(empty8), .dropped_o(drop8), .status_o(stat8));

  int nChecks = 0;
  int nFails  = 0;

  // Model: buffers are allocated in sequence numbers; held = [relCnt, allocCnt), index = seq mod N
  int nb[2] = '{4, 8};
  int allocCnt[2], relCnt[2], lastAcc[2], mDrop[2], mBuf[2], mEvid[2], mEpoch[2];
  bit haveAcc[2], mAcc[2];
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelHold(input int k);
    logic [31:0] h = '0;
    for (int s = relCnt[k]; s < allocCnt[k]; s++) h[s % nb[k]] = 1'b1;
    return h;
  endfunction

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        allocCnt[k] = 0; relCnt[k] = 0; lastAcc[k] = 0; haveAcc[k] = 0;
        mDrop[k] = 0; mBuf[k] = 0; mAcc[k] = 0; mEvid[k] = 0; mEpoch[k] = 0;
      end else begin
        int  occ     = allocCnt[k] - relCnt[k];
        bit  isFull  = (occ == nb[k]);
        bit  blocked = haveAcc[k] && ((cyc - lastAcc[k]) <= 8);
        bit  acc     = trig && !dis && !isFull && !blocked && !clr_all;
        bit  drp     = trig && !dis && (isFull || blocked) && !clr_all;
        mAcc[k] = acc;
        if (evid_reset) begin
          mEpoch[k] = epoch;
          mEvid[k]  = acc ? 1 : 0;
        end else if (acc) begin
          mEvid[k] = (mEvid[k] + 1) % (1 << 20);
        end
        if (clr_all) begin
          allocCnt[k] = 0; relCnt[k] = 0; haveAcc[k] = 0; mDrop[k] = 0;
        end else begin
          if (acc) begin
            mBuf[k] = allocCnt[k] % nb[k];
            allocCnt[k]++;
            lastAcc[k] = cyc;
            haveAcc[k] = 1;
          end
          if (clr_evt && occ > 0) relCnt[k]++;
          if (drp && mDrop[k] < 65535) mDrop[k]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic checkInst(input int k, input logic [31:0] hold, input logic acc, input logic [31:0] bufi,
                           input logic [31:0] id, input logic [31:0] occ, input logic full,
                           input logic empty, input logic [15:0] drp, input logic [31:0] stat);
    logic [31:0] eHold = modelHold(k);
    int          eOcc  = allocCnt[k] - relCnt[k];
    logic [31:0] eId   = {mEpoch[k][11:0], mEvid[k][19:0]};
    logic [31:0] eStat = {mDrop[k][15:0], 8'h00, eOcc[7:0], eHold[7:0]};
    string       p     = (k == 0) ? "m4" : "m8";
    checkOutput({p, ".hold"},   hold, eHold);
    checkOutput({p, ".accept"}, 32'(acc), 32'(mAcc[k]));
    checkOutput({p, ".buf"},    bufi, 32'(mBuf[k]));
    checkOutput({p, ".id"},     id, eId);
    checkOutput({p, ".occ"},    occ, 32'(eOcc));
    checkOutput({p, ".full"},   32'(full), 32'(eOcc == nb[k]));
    checkOutput({p, ".empty"},  32'(empty), 32'(eOcc == 0));
    checkOutput({p, ".dropped"}, 32'(drp), 32'(mDrop[k]));
    checkOutput({p, ".status"}, stat, eStat);
  endtask

  // One clock with the current inputs, model update on the edge, compare 1 ns later
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkInst(0, 32'(hold4), acc4, 32'(buf4), id4, 32'(occ4), full4, empty4, drop4, stat4);
    checkInst(1, 32'(hold8), acc8, 32'(buf8), id8, 32'(occ8), full8, empty8, drop8, stat8);
    trig = 0; clr_evt = 0; clr_all = 0; evid_reset = 0;
  endtask

  task automatic applyStimulus(input bit t, input bit ce, input bit ca, input bit er, input logic [11:0] ep);
    trig = t; clr_evt = ce; clr_all = ca; evid_reset = er; epoch = ep;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit          t, ce, ca, er;
    logic [11:0] ep;
    logic [3:0]  eHold;
    int          eOcc, eDrop, eBuf;
    logic [31:0] eId;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 12'h000, 4'b0001, 1, 0, 0, 32'h00000001};
    vecs[1]  = '{1, 0, 0, 0, 12'h000, 4'b0011, 2, 0, 1, 32'h00000002};
    vecs[2]  = '{1, 0, 0, 0, 12'h000, 4'b0111, 3, 0, 2, 32'h00000003};
    vecs[3]  = '{1, 0, 0, 0, 12'h000, 4'b1111, 4, 0, 3, 32'h00000004};
    vecs[4]  = '{1, 0, 0, 0, 12'h000, 4'b1111, 4, 1, 3, 32'h00000004};
    vecs[5]  = '{1, 0, 0, 0, 12'h000, 4'b1111, 4, 2, 3, 32'h00000004};
    vecs[6]  = '{1, 0, 0, 0, 12'h000, 4'b1111, 4, 3, 3, 32'h00000004};
    vecs[7]  = '{0, 1, 0, 0, 12'h000, 4'b1110, 3, 3, 3, 32'h00000004};
    vecs[8]  = '{1, 0, 0, 0, 12'h000, 4'b1111, 4, 3, 0, 32'h00000005};
    vecs[9]  = '{0, 0, 1, 0, 12'h000, 4'b0000, 0, 0, 0, 32'h00000005};
    vecs[10] = '{0, 0, 0, 1, 12'hABC, 4'b0000, 0, 0, 0, 32'hABC00000};
    vecs[11] = '{1, 0, 0, 0, 12'hABC, 4'b0001, 1, 0, 0, 32'hABC00001};

    rst = 1; trig = 0; dis = 0; clr_evt = 0; clr_all = 0; evid_reset = 0; epoch = '0;
    idle(2);
    rst = 0;
    checkOutput("reset.hold",  32'(hold4), 32'h0);
    checkOutput("reset.empty", 32'(empty4), 32'h1);
    checkOutput("reset.full",  32'(full4), 32'h0);
    checkOutput("reset.id",    id4, 32'h0);
    checkOutput("reset.drop",  32'(drop4), 32'h0);
    idle(2);

    $display("[TB] directed table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].t, vecs[i].ce, vecs[i].ca, vecs[i].er, vecs[i].ep);
      idle(9);
      checkOutput($sformatf("vec%0d.hold", i), 32'(hold4), 32'(vecs[i].eHold));
      checkOutput($sformatf("vec%0d.occ", i),  32'(occ4),  32'(vecs[i].eOcc));
      checkOutput($sformatf("vec%0d.drop", i), 32'(drop4), 32'(vecs[i].eDrop));
      checkOutput($sformatf("vec%0d.buf", i),  32'(buf4),  32'(vecs[i].eBuf));
      checkOutput($sformatf("vec%0d.id", i),   id4, vecs[i].eId);
    end

    $display("[TB] holdoff window");
    applyStimulus(0, 0, 1, 0, 12'hABC);
    idle(10);
    applyStimulus(1, 0, 0, 0, 12'hABC);
    idle(2);
    applyStimulus(1, 0, 0, 0, 12'hABC);
    checkOutput("holdoff.drop", 32'(drop4), 32'd1);
    checkOutput("holdoff.occ",  32'(occ4),  32'd1);
    idle(5);
    applyStimulus(1, 0, 0, 0, 12'hABC);
    checkOutput("holdoff.acc9", 32'(acc4), 32'd1);
    checkOutput("holdoff.occ9", 32'(occ4), 32'd2);

    $display("[TB] simultaneous accept and clear");
    idle(10);
    applyStimulus(1, 1, 0, 0, 12'hABC);
    checkOutput("simul.occ",  32'(occ4),  32'd2);
    checkOutput("simul.acc",  32'(acc4),  32'd1);
    checkOutput("simul.hold", 32'(hold4), 32'b0110);
    checkOutput("simul.buf",  32'(buf4),  32'd2);

    $display("[TB] reset inside holdoff");
    rst = 1;
    tick();
    rst = 0;
    checkOutput("midrst.hold",  32'(hold4), 32'h0);
    checkOutput("midrst.empty", 32'(empty4), 32'h1);
    checkOutput("midrst.id",    id4, 32'h0);
    applyStimulus(1, 0, 0, 0, 12'h000);
    checkOutput("midrst.acc", 32'(acc4), 32'd1);

    $display("[TB] clear-all override and empty clear");
    idle(10);
    applyStimulus(1, 0, 1, 0, 12'h000);
    checkOutput("clrall.acc",  32'(acc4), 32'd0);
    checkOutput("clrall.drop", 32'(drop4), 32'd0);
    checkOutput("clrall.id",   id4, 32'd1);
    applyStimulus(0, 1, 0, 0, 12'h000);
    checkOutput("emptyclr.occ", 32'(occ4), 32'd0);

    $display("[TB] eight-buffer wrap");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 0, 0, 12'h000);
      idle(9);
    end
    checkOutput("wrap8.hold", 32'(hold8), 32'hFF);
    checkOutput("wrap8.drop", 32'(drop8), 32'd1);
    checkOutput("wrap8.full", 32'(full8), 32'd1);
    checkOutput("wrap8.drop4", 32'(drop4), 32'd5);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 12'h000);
    checkOutput("wrap8.cleared", 32'(hold8), 32'h00);
    applyStimulus(1, 0, 0, 0, 12'h000);
    checkOutput("wrap8.buf0",  32'(buf8),  32'd0);
    checkOutput("wrap8.hold0", 32'(hold8), 32'h01);

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      dis        = ($urandom_range(0, 7) == 0);
      trig       = ($urandom_range(0, 2) == 0);
      clr_evt    = ($urandom_range(0, 3) == 0);
      clr_all    = ($urandom_range(0, 59) == 0);
      evid_reset = ($urandom_range(0, 49) == 0);
      epoch      = 12'($urandom);
      tick();
      rst = 0;
    end
    dis = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
